// File: rtl/bean_tracker.sv
// bean_tracker: owns the 40x30 bean occupancy map shown by the display.
// Each game tick it looks up the tile under Pacman's sprite centre.
// If that tile holds a bean, it eats the bean, bumps the score and
// counts down the remaining beans. all_eaten flags an empty map.
module bean_tracker #(
  parameter int COLS       = 40,
  parameter int ROWS       = 30,
  parameter int TILE_SHIFT = 4,
  parameter int SPR_HALF   = 16,
  parameter logic [COLS*ROWS-1:0] INIT_MAP = '0,
  parameter int BEAN_TOTAL = 0
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 tick,
  input  logic                 restart,
  input  logic                 over,
  input  logic [9:0]           PacX,
  input  logic [8:0]           PacY,
  output logic [COLS*ROWS-1:0] beanmap,
  output logic [10:0]          score,
  output logic                 eat_pulse,
  output logic                 all_eaten,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [10:0] SCORE_MAX  = 11'h7FF;
  localparam logic [10:0] TOTAL_INIT = 11'(BEAN_TOTAL);

  state_t      state;
  logic [10:0] cx;
  logic [9:0]  cy;
  logic [10:0] idx;
  logic        valid;
  logic [10:0] remaining;

  logic [6:0]  col;
  logic [5:0]  row;
  logic        next_valid;
  logic [10:0] next_idx;

  // Tile coordinates of the latched sprite centre and the matching map index.
  // The product uses only the row/col bits that can be in range; out-of-range
  // tiles are caught by next_valid, so the index is never trusted for them.
  always_comb begin
    col        = 7'(cx >> TILE_SHIFT);
    row        = 6'(cy >> TILE_SHIFT);
    next_valid = (32'(col) < COLS) && (32'(row) < ROWS);
    next_idx   = 11'(row[4:0]) * 11'(COLS) + 11'(col[5:0]);
  end

  // Lookup FSM with registered outputs; restart behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (!clrn || restart) begin
      state     <= IDLE;
      beanmap   <= INIT_MAP;
      score     <= '0;
      remaining <= TOTAL_INIT;
      all_eaten <= (TOTAL_INIT == 11'd0);
      eat_pulse <= 1'b0;
      busy      <= 1'b0;
      cx        <= '0;
      cy        <= '0;
      idx       <= '0;
      valid     <= 1'b0;
    end else begin
      eat_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (tick && !over && !all_eaten) begin
            cx    <= {1'b0, PacX} + 11'(SPR_HALF);
            cy    <= {1'b0, PacY} + 10'(SPR_HALF);
            busy  <= 1'b1;
            state <= LATCH;
          end
        end
        LATCH: begin
          idx   <= next_idx;
          valid <= next_valid;
          state <= CHECK;
        end
        CHECK: begin
          if (valid && beanmap[idx]) begin
            beanmap[idx] <= 1'b0;
            if (score != SCORE_MAX) begin
              score <= score + 11'd1;
            end
            remaining <= remaining - 11'd1;
            all_eaten <= (remaining == 11'd1);
            eat_pulse <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bean_tracker.sv
// tb_bean_tracker: directed scenario tests for bean_tracker with a single
// bean at tile (col 1, row 1), map index 41.
module tb_bean_tracker;

  localparam logic [1199:0] MAP_INIT = 1200'b1 << 41;

  logic          clk;
  logic          clrn;
  logic          tick;
  logic          restart;
  logic          over;
  logic [9:0]    PacX;
  logic [8:0]    PacY;
  logic [1199:0] beanmap;
  logic [10:0]   score;
  logic          eat_pulse;
  logic          all_eaten;
  logic          busy;

  int checks = 0;
  int errors = 0;

  bean_tracker #(
    .COLS(40), .ROWS(30), .TILE_SHIFT(4), .SPR_HALF(16),
    .INIT_MAP(MAP_INIT), .BEAN_TOTAL(1)
  ) dut (
    .clk(clk), .clrn(clrn), .tick(tick), .restart(restart), .over(over),
    .PacX(PacX), .PacY(PacY), .beanmap(beanmap), .score(score),
    .eat_pulse(eat_pulse), .all_eaten(all_eaten), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clrn = 1'b0; tick = 1'b0; restart = 1'b0; over = 1'b0; PacX = '0; PacY = '0;
    step(); step();
    clrn = 1'b1;
    checks++;
    if (beanmap !== MAP_INIT) begin
      errors++;
      $display("[TB] FAIL reset_map: got low=%h ones=%0d, expected low=%h ones=1", beanmap[63:0], $countones(beanmap), MAP_INIT[63:0]);
    end
    checks++;
    if (score !== 11'd0) begin errors++; $display("[TB] FAIL reset_score: got %0d expected 0", score); end
    checks++;
    if (all_eaten !== 1'b0) begin errors++; $display("[TB] FAIL reset_all_eaten: got %b expected 0", all_eaten); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (eat_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_eat_pulse: got %b expected 0", eat_pulse); end
  endtask

  task automatic test_eat();
    PacX = 10'd0; PacY = 9'd0; tick = 1'b1;
    step();
    tick = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL eat_busy_n1: got %b expected 1", busy); end
    checks++;
    if (beanmap[41] !== 1'b1) begin errors++; $display("[TB] FAIL eat_early_map: got %b expected 1", beanmap[41]); end
    step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL eat_busy_n2: got %b expected 1", busy); end
    checks++;
    if (score !== 11'd0) begin errors++; $display("[TB] FAIL eat_early_score: got %0d expected 0", score); end
    step();
    checks++;
    if (beanmap !== 1200'b0) begin errors++; $display("[TB] FAIL eat_map: got low=%h ones=%0d, expected all zero", beanmap[63:0], $countones(beanmap)); end
    checks++;
    if (score !== 11'd1) begin errors++; $display("[TB] FAIL eat_score: got %0d expected 1", score); end
    checks++;
    if (eat_pulse !== 1'b1) begin errors++; $display("[TB] FAIL eat_pulse_on: got %b expected 1", eat_pulse); end
    checks++;
    if (all_eaten !== 1'b1) begin errors++; $display("[TB] FAIL eat_all_eaten: got %b expected 1", all_eaten); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL eat_busy_done: got %b expected 0", busy); end
    step();
    checks++;
    if (eat_pulse !== 1'b0) begin errors++; $display("[TB] FAIL eat_pulse_off: got %b expected 0", eat_pulse); end
  endtask

  task automatic test_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks++;
    if (beanmap !== MAP_INIT) begin errors++; $display("[TB] FAIL restart_map: got low=%h expected low=%h", beanmap[63:0], MAP_INIT[63:0]); end
    checks++;
    if (score !== 11'd0) begin errors++; $display("[TB] FAIL restart_score: got %0d expected 0", score); end
    checks++;
    if (all_eaten !== 1'b0) begin errors++; $display("[TB] FAIL restart_all_eaten: got %b expected 0", all_eaten); end
    PacX = 10'd0; PacY = 9'd0; tick = 1'b1;
    step();
    tick = 1'b0;
    step(); step();
    checks++;
    if (score !== 11'd1 || beanmap[41] !== 1'b0) begin
      errors++; $display("[TB] FAIL restart_reeat: got score=%0d bit41=%b expected score=1 bit41=0", score, beanmap[41]);
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL eaten_tile_busy: got %b expected 0", busy); end
    step(); step();
    checks++;
    if (score !== 11'd1 || eat_pulse !== 1'b0 || beanmap !== 1200'b0) begin
      errors++; $display("[TB] FAIL eaten_tile_nochange: got score=%0d pulse=%b ones=%0d expected 1 0 0", score, eat_pulse, $countones(beanmap));
    end
  endtask

  task automatic test_off_grid();
    restart = 1'b1;
    step();
    restart = 1'b0;
    PacX = 10'd630; PacY = 9'd0; tick = 1'b1;
    step();
    tick = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL offgrid_busy1: got %b expected 1", busy); end
    step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL offgrid_busy2: got %b expected 1", busy); end
    step();
    checks++;
    if (busy !== 1'b0 || eat_pulse !== 1'b0) begin
      errors++; $display("[TB] FAIL offgrid_col_done: got busy=%b pulse=%b expected 0 0", busy, eat_pulse);
    end
    checks++;
    if (beanmap !== MAP_INIT || score !== 11'd0) begin
      errors++; $display("[TB] FAIL offgrid_col_nochange: got score=%0d ones=%0d expected 0 1", score, $countones(beanmap));
    end
    PacX = 10'd0; PacY = 9'd464; tick = 1'b1;
    step();
    tick = 1'b0;
    step(); step();
    checks++;
    if (beanmap !== MAP_INIT || score !== 11'd0 || eat_pulse !== 1'b0) begin
      errors++; $display("[TB] FAIL offgrid_row: got score=%0d pulse=%b ones=%0d expected 0 0 1", score, eat_pulse, $countones(beanmap));
    end
  endtask

  task automatic test_back_to_back();
    PacX = 10'd0; PacY = 9'd0; tick = 1'b1;
    step(); step();
    tick = 1'b0;
    step();
    checks++;
    if (eat_pulse !== 1'b1 || score !== 11'd1) begin
      errors++; $display("[TB] FAIL b2b_eat: got pulse=%b score=%0d expected 1 1", eat_pulse, score);
    end
    step();
    checks++;
    if (eat_pulse !== 1'b0 || busy !== 1'b0 || score !== 11'd1) begin
      errors++; $display("[TB] FAIL b2b_single: got pulse=%b busy=%b score=%0d expected 0 0 1", eat_pulse, busy, score);
    end
    tick = 1'b1; restart = 1'b1;
    step();
    tick = 1'b0; restart = 1'b0;
    checks++;
    if (busy !== 1'b0 || score !== 11'd0 || beanmap !== MAP_INIT) begin
      errors++; $display("[TB] FAIL tick_restart_same: got busy=%b score=%0d ones=%0d expected 0 0 1", busy, score, $countones(beanmap));
    end
    tick = 1'b1;
    step();
    tick = 1'b0; restart = 1'b1;
    step();
    restart = 1'b0;
    step(); step();
    checks++;
    if (busy !== 1'b0 || score !== 11'd0 || beanmap !== MAP_INIT || eat_pulse !== 1'b0) begin
      errors++; $display("[TB] FAIL restart_abort: got busy=%b score=%0d pulse=%b ones=%0d expected 0 0 0 1", busy, score, eat_pulse, $countones(beanmap));
    end
  endtask

  task automatic test_over();
    over = 1'b1; PacX = 10'd0; PacY = 9'd0; tick = 1'b1;
    step();
    tick = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL over_busy: got %b expected 0", busy); end
    step(); step();
    checks++;
    if (score !== 11'd0 || beanmap !== MAP_INIT) begin
      errors++; $display("[TB] FAIL over_frozen: got score=%0d ones=%0d expected 0 1", score, $countones(beanmap));
    end
    over = 1'b0; tick = 1'b1;
    step();
    tick = 1'b0; over = 1'b1;
    step(); step();
    checks++;
    if (score !== 11'd1 || eat_pulse !== 1'b1 || beanmap[41] !== 1'b0) begin
      errors++; $display("[TB] FAIL over_midlookup: got score=%0d pulse=%b bit41=%b expected 1 1 0", score, eat_pulse, beanmap[41]);
    end
    over = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_eat();
    test_restart();
    test_off_grid();
    test_back_to_back();
    test_over();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
